// File: rtl/davinci_outfifo_packer_if.sv
// rtl/davinci_outfifo_packer_if.sv - packed-beat output stream between packer and host
interface davinci_outfifo_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK       = 2
);
  logic [PACK*DATA_WIDTH-1:0] m_data;
  logic [PACK-1:0]            m_keep;
  logic                       m_last;
  logic                       m_valid;
  logic                       m_ready;

  modport master (output m_data, output m_keep, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_keep, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/davinci_outfifo_packer.sv
// rtl/davinci_outfifo_packer.sv - packs DA-VinCi FIFO-out words into wide beats behind a FWFT FIFO
module davinci_outfifo_packer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ATTRIB_WIDTH = 2,
  parameter int EOV_BIT      = 0,
  parameter int PACK         = 2,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic [ATTRIB_WIDTH-1:0]   attribIn,
  input  logic                      dataInValid,
  davinci_outfifo_packer_if.master  m,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pendingVectors,
  output logic                      overflow,
  input  logic                      clearOverflow
);
  localparam int LW  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;
  localparam int BW  = PACK * DATA_WIDTH;
  localparam logic [LW-1:0]  LANE_MAX = LW'(PACK - 1);
  localparam logic [LVW-1:0] DEPTH_L  = LVW'(DEPTH);

  logic [LW-1:0]  lane_q, lane_d;
  logic [BW-1:0]  pack_q, pack_d;
  logic [PACK-1:0] keep_q, keep_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0] level_q, level_d, pend_q, pend_d;
  logic           ovf_q, ovf_d;

  logic [BW-1:0]   mem_data [DEPTH];
  logic [PACK-1:0] mem_keep [DEPTH];
  logic            mem_last [DEPTH];

  logic [BW-1:0]   beat_data;
  logic [PACK-1:0] beat_keep;
  logic            beat_last, complete, pop, push_ok, head_last;

  // Incoming word merged into the partial pack; unfilled lanes stay zero.
  always_comb begin
    beat_data = pack_q;
    beat_keep = keep_q;
    for (int i = 0; i < PACK; i++) begin
      if (lane_q == LW'(i)) begin
        beat_data[i*DATA_WIDTH +: DATA_WIDTH] = dataIn;
        beat_keep[i] = 1'b1;
      end
    end
  end

  assign beat_last = attribIn[EOV_BIT];
  assign complete  = dataInValid && ((lane_q == LANE_MAX) || beat_last);
  assign head_last = mem_last[rd_ptr_q];
  assign pop       = (level_q != '0) && m.m_ready;
  assign push_ok   = complete && ((level_q < DEPTH_L) || pop);

  always_comb begin
    lane_d   = lane_q;
    pack_d   = pack_q;
    keep_d   = keep_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;

    if (complete) begin
      lane_d = '0;
      pack_d = '0;
      keep_d = '0;
    end else if (dataInValid) begin
      lane_d = lane_q + 1'b1;
      pack_d = beat_data;
      keep_d = beat_keep;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case ({push_ok && beat_last, pop && head_last})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (complete && !push_ok) ovf_d = 1'b1;
    else if (clearOverflow)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q   <= '0;
      pack_q   <= '0;
      keep_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      keep_q   <= keep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_data[wr_ptr_q] <= beat_data;
      mem_keep[wr_ptr_q] <= beat_keep;
      mem_last[wr_ptr_q] <= beat_last;
    end
  end

  assign m.m_data       = mem_data[rd_ptr_q];
  assign m.m_keep       = mem_keep[rd_ptr_q];
  assign m.m_last       = head_last;
  assign m.m_valid      = (level_q != '0);
  assign level          = level_q;
  assign pendingVectors = pend_q;
  assign overflow       = ovf_q;
endmodule
